// File: rtl/mem_port_arbiter_if.sv
// Enable/ready bundle between two requesters, the arbiter and the memory.
// slave is the arbiter's view; master is the surrounding core/memory/testbench view.
interface mem_port_arbiter_if;
  logic        EN_rq0_put;
  logic [64:0] rq0_put;
  logic        RDY_rq0_put;
  logic        EN_rq1_put;
  logic [64:0] rq1_put;
  logic        RDY_rq1_put;
  logic        EN_rs0_get;
  logic [31:0] rs0_get;
  logic        RDY_rs0_get;
  logic        EN_rs1_get;
  logic [31:0] rs1_get;
  logic        RDY_rs1_get;
  logic        EN_mem_rq_get;
  logic [64:0] mem_rq_get;
  logic        RDY_mem_rq_get;
  logic        EN_mem_rs_put;
  logic [31:0] mem_rs_put;
  logic        RDY_mem_rs_put;

  modport slave (
    input  EN_rq0_put, rq0_put, EN_rq1_put, rq1_put, EN_rs0_get, EN_rs1_get,
    input  EN_mem_rq_get, EN_mem_rs_put, mem_rs_put,
    output RDY_rq0_put, RDY_rq1_put, rs0_get, RDY_rs0_get, rs1_get, RDY_rs1_get,
    output mem_rq_get, RDY_mem_rq_get, RDY_mem_rs_put
  );

  modport master (
    output EN_rq0_put, rq0_put, EN_rq1_put, rq1_put, EN_rs0_get, EN_rs1_get,
    output EN_mem_rq_get, EN_mem_rs_put, mem_rs_put,
    input  RDY_rq0_put, RDY_rq1_put, rs0_get, RDY_rs0_get, rs1_get, RDY_rs1_get,
    input  mem_rq_get, RDY_mem_rq_get, RDY_mem_rs_put
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (0) and load/store (1).
// Optional MEM_ARB_PERF_EN adds grant and tag-stall counters.
module mem_port_arbiter #(
  parameter int unsigned TAG_DEPTH  = 4,
  parameter bit          RESET_LAST = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       grant0_count,
  output logic [31:0]       grant1_count,
  output logic [31:0]       stall_count
`endif
);
  localparam int unsigned TW = (TAG_DEPTH > 2) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CW = TW + 1;
  localparam logic [CW-1:0] TAG_FULL = CW'(TAG_DEPTH);

  logic [1:0]    w_in_en, w_in_ne, w_pop, w_rs_deq;
  logic [64:0]   w_in_data [2];
  logic [64:0]   r_in_mem [2][2];
  logic [1:0]    r_in_rd, r_in_wr;
  logic [1:0]    r_in_cnt [2];
  logic          r_out_valid, r_out_tag, r_last;
  logic [64:0]   r_out_data;
  logic          w_load, w_grant, w_gnt;
  logic          r_tag_mem [TAG_DEPTH];
  logic [TW-1:0] r_tag_rd, r_tag_wr;
  logic [CW-1:0] r_tag_cnt;
  logic          w_head_tag, w_tag_push, w_tag_pop;
  logic [1:0]    r_rs_valid;
  logic [31:0]   r_rs_data [2];

  assign w_in_en      = {bus.EN_rq1_put, bus.EN_rq0_put};
  assign w_in_data[0] = bus.rq0_put;
  assign w_in_data[1] = bus.rq1_put;
  assign w_rs_deq     = {bus.EN_rs1_get, bus.EN_rs0_get};
  assign w_tag_push   = bus.EN_mem_rq_get;
  assign w_tag_pop    = bus.EN_mem_rs_put;
  assign w_head_tag   = r_tag_mem[r_tag_rd];

  // Input FIFO count is 0 in reset, so gate with RST_N to keep RDY low there.
  assign bus.RDY_rq0_put    = RST_N && (r_in_cnt[0] != 2'd2);
  assign bus.RDY_rq1_put    = RST_N && (r_in_cnt[1] != 2'd2);
  assign bus.RDY_mem_rq_get = r_out_valid && (r_tag_cnt != TAG_FULL);
  assign bus.RDY_mem_rs_put = (r_tag_cnt != '0) && !r_rs_valid[w_head_tag];
  assign bus.mem_rq_get     = r_out_data;
  assign bus.RDY_rs0_get    = r_rs_valid[0];
  assign bus.RDY_rs1_get    = r_rs_valid[1];
  assign bus.rs0_get        = r_rs_data[0];
  assign bus.rs1_get        = r_rs_data[1];

  always_comb begin
    w_in_ne = 2'b00;
    for (int i = 0; i < 2; i++) w_in_ne[i] = (r_in_cnt[i] != 2'd0);
    w_load  = !r_out_valid || bus.EN_mem_rq_get;
    w_grant = w_load && (|w_in_ne);
    // On a tie the side that did not win last time goes next.
    w_gnt   = (&w_in_ne) ? ~r_last : w_in_ne[1];
    w_pop   = w_grant ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_in_rd     <= '0;
      r_in_wr     <= '0;
      r_in_cnt[0] <= '0;
      r_in_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_in_en[i]) r_in_wr[i] <= ~r_in_wr[i];
        if (w_pop[i])   r_in_rd[i] <= ~r_in_rd[i];
        r_in_cnt[i] <= r_in_cnt[i] + {1'b0, w_in_en[i]} - {1'b0, w_pop[i]};
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (w_in_en[i]) r_in_mem[i][r_in_wr[i]] <= w_in_data[i];
    end
    if (w_tag_push) r_tag_mem[r_tag_wr] <= r_out_tag;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_out_valid <= 1'b0;
      r_out_tag   <= 1'b0;
      r_out_data  <= '0;
      r_last      <= RESET_LAST;
    end else if (w_grant) begin
      r_out_valid <= 1'b1;
      r_out_tag   <= w_gnt;
      r_out_data  <= r_in_mem[w_gnt][r_in_rd[w_gnt]];
      r_last      <= w_gnt;
    end else if (bus.EN_mem_rq_get) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tag_rd  <= '0;
      r_tag_wr  <= '0;
      r_tag_cnt <= '0;
    end else begin
      if (w_tag_push) r_tag_wr <= r_tag_wr + TW'(1);
      if (w_tag_pop)  r_tag_rd <= r_tag_rd + TW'(1);
      r_tag_cnt <= r_tag_cnt + CW'(w_tag_push) - CW'(w_tag_pop);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rs_valid   <= '0;
      r_rs_data[0] <= '0;
      r_rs_data[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_rs_deq[i]) r_rs_valid[i] <= 1'b0;
      end
      if (w_tag_pop) begin
        r_rs_valid[w_head_tag] <= 1'b1;
        r_rs_data[w_head_tag]  <= bus.mem_rs_put;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_grant0_cnt, r_grant1_cnt, r_stall_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_grant0_cnt <= '0;
      r_grant1_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (bus.EN_mem_rq_get && !r_out_tag) r_grant0_cnt <= r_grant0_cnt + 32'd1;
      if (bus.EN_mem_rq_get && r_out_tag)  r_grant1_cnt <= r_grant1_cnt + 32'd1;
      if (r_out_valid && (r_tag_cnt == TAG_FULL)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign grant0_count = r_grant0_cnt;
  assign grant1_count = r_grant1_cnt;
  assign stall_count  = r_stall_cnt;
`endif

`ifndef SYNTHESIS
  a_rq0: assert property (@(posedge CLK) disable iff (!RST_N) bus.EN_rq0_put |-> bus.RDY_rq0_put);
  a_rq1: assert property (@(posedge CLK) disable iff (!RST_N) bus.EN_rq1_put |-> bus.RDY_rq1_put);
  a_rs0: assert property (@(posedge CLK) disable iff (!RST_N) bus.EN_rs0_get |-> bus.RDY_rs0_get);
  a_rs1: assert property (@(posedge CLK) disable iff (!RST_N) bus.EN_rs1_get |-> bus.RDY_rs1_get);
  a_mrq: assert property (@(posedge CLK) disable iff (!RST_N)
                          bus.EN_mem_rq_get |-> bus.RDY_mem_rq_get);
  a_mrs: assert property (@(posedge CLK) disable iff (!RST_N)
                          bus.EN_mem_rs_put |-> bus.RDY_mem_rs_put);
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed test-plan scenarios plus a randomized run scored against per-requester queues.
module tb_mem_port_arbiter;
  localparam int unsigned TAG_DEPTH = 4;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  mem_port_arbiter_if bus ();
`ifdef MEM_ARB_PERF_EN
  logic [31:0] grant0_count, grant1_count, stall_count;
`endif

  mem_port_arbiter #(.TAG_DEPTH(TAG_DEPTH), .RESET_LAST(1'b1)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .grant0_count(grant0_count),
    .grant1_count(grant1_count),
    .stall_count (stall_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [64:0] stim0[$], stim1[$], sent0[$], sent1[$], mem_log[$];
  logic [31:0] exp0[$], exp1[$], rx0[$], rx1[$], pend[$];
  int          issued0, issued1;
  bit          seq_resp;
  logic [31:0] resp_seq;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [64:0] r);
    return r[64:33] ^ r[31:0] ^ {r[32], 31'h1A5A_0F0F};
  endfunction

  task automatic idle();
    bus.EN_rq0_put = 1'b0; bus.EN_rq1_put = 1'b0;
    bus.EN_rs0_get = 1'b0; bus.EN_rs1_get = 1'b0;
    bus.EN_mem_rq_get = 1'b0; bus.EN_mem_rs_put = 1'b0;
  endtask

  // One clock of requester/memory behaviour; entered and left at a falling edge.
  task automatic cycle(input int p_put, input int p_take, input int p_resp, input int p_deq);
    logic [64:0] req;
    logic [31:0] v;
    bit m0, m1;
    idle();
    if (stim0.size() > 0 && bus.RDY_rq0_put && $urandom_range(99) < p_put) begin
      bus.rq0_put = stim0.pop_front(); bus.EN_rq0_put = 1'b1; sent0.push_back(bus.rq0_put);
    end
    if (stim1.size() > 0 && bus.RDY_rq1_put && $urandom_range(99) < p_put) begin
      bus.rq1_put = stim1.pop_front(); bus.EN_rq1_put = 1'b1; sent1.push_back(bus.rq1_put);
    end
    if (bus.RDY_mem_rs_put && $urandom_range(99) < p_resp) begin
      check("mem_rs_rdy_has_pending", 65'(pend.size() > 0), 65'd1);
      if (pend.size() > 0) begin
        bus.mem_rs_put = pend.pop_front(); bus.EN_mem_rs_put = 1'b1;
      end
    end
    if (bus.RDY_mem_rq_get && $urandom_range(99) < p_take) begin
      req = bus.mem_rq_get;
      m0 = sent0.size() > 0 && req == sent0[0];
      m1 = sent1.size() > 0 && req == sent1[0];
      check("mem_rq_is_oldest_of_a_requester", 65'(m0 || m1), 65'd1);
      v = seq_resp ? resp_seq : mem_fn(req);
      resp_seq++;
      mem_log.push_back(req);
      pend.push_back(v);
      if (m0) begin void'(sent0.pop_front()); exp0.push_back(v); issued0++; end
      else if (m1) begin void'(sent1.pop_front()); exp1.push_back(v); issued1++; end
      bus.EN_mem_rq_get = 1'b1;
    end
    if (bus.RDY_rs0_get && $urandom_range(99) < p_deq) begin
      check("rs0_has_expected", 65'(exp0.size() > 0), 65'd1);
      if (exp0.size() > 0) check("rs0_data", 65'(bus.rs0_get), 65'(exp0.pop_front()));
      rx0.push_back(bus.rs0_get); bus.EN_rs0_get = 1'b1;
    end
    if (bus.RDY_rs1_get && $urandom_range(99) < p_deq) begin
      check("rs1_has_expected", 65'(exp1.size() > 0), 65'd1);
      if (exp1.size() > 0) check("rs1_data", 65'(bus.rs1_get), 65'(exp1.pop_front()));
      rx1.push_back(bus.rs1_get); bus.EN_rs1_get = 1'b1;
    end
    @(negedge CLK);
  endtask

  task automatic do_reset(input bit check_it);
    idle();
    RST_N = 1'b0;
    bus.EN_rq0_put = 1'b1;
    bus.rq0_put = 65'h1_2345;
    repeat (3) begin
      @(negedge CLK);
      if (check_it) begin
        check("rst_rdy_rq0", 65'(bus.RDY_rq0_put), 65'd0);
        check("rst_rdy_rq1", 65'(bus.RDY_rq1_put), 65'd0);
        check("rst_rdy_mem_rq", 65'(bus.RDY_mem_rq_get), 65'd0);
        check("rst_rdy_mem_rs", 65'(bus.RDY_mem_rs_put), 65'd0);
        check("rst_rdy_rs0", 65'(bus.RDY_rs0_get), 65'd0);
        check("rst_rdy_rs1", 65'(bus.RDY_rs1_get), 65'd0);
        check("rst_mem_rq", bus.mem_rq_get, 65'd0);
      end
    end
    bus.EN_rq0_put = 1'b0;
    RST_N = 1'b1;
    stim0.delete(); stim1.delete(); sent0.delete(); sent1.delete(); mem_log.delete();
    exp0.delete(); exp1.delete(); rx0.delete(); rx1.delete(); pend.delete();
    issued0 = 0; issued1 = 0; resp_seq = 32'd1;
    @(negedge CLK);
    if (check_it) begin
      check("post_rst_rdy_rq0", 65'(bus.RDY_rq0_put), 65'd1);
      check("post_rst_rdy_rq1", 65'(bus.RDY_rq1_put), 65'd1);
      @(negedge CLK);
      check("post_rst_no_issue", 65'(bus.RDY_mem_rq_get), 65'd0);
    end
  endtask

  initial begin
    bit done;
    RST_N = 1'b0;
    idle();
    bus.rq0_put = '0; bus.rq1_put = '0; bus.mem_rs_put = '0;
    seq_resp = 1'b1;
    do_reset(1'b1);

    // Single read from requester 0.
    bus.rq0_put = {32'h100, 1'b0, 32'h0}; bus.EN_rq0_put = 1'b1;
    @(negedge CLK); bus.EN_rq0_put = 1'b0;
    @(negedge CLK);
    check("rd_mem_rq_rdy", 65'(bus.RDY_mem_rq_get), 65'd1);
    check("rd_mem_rq_addr", 65'(bus.mem_rq_get[64:33]), 65'h100);
    bus.EN_mem_rq_get = 1'b1;
    @(negedge CLK); bus.EN_mem_rq_get = 1'b0;
    check("rd_mem_rs_rdy", 65'(bus.RDY_mem_rs_put), 65'd1);
    bus.mem_rs_put = 32'hDEADBEEF; bus.EN_mem_rs_put = 1'b1;
    @(negedge CLK); bus.EN_mem_rs_put = 1'b0;
    @(negedge CLK);
    check("rd_rs0_data", 65'(bus.rs0_get), 65'hDEADBEEF);
    check("rd_rs0_rdy", 65'(bus.RDY_rs0_get), 65'd1);
    check("rd_rs1_quiet", 65'(bus.RDY_rs1_get), 65'd0);
    bus.EN_rs0_get = 1'b1;
    @(negedge CLK); bus.EN_rs0_get = 1'b0;
    check("rd_rs0_cleared", 65'(bus.RDY_rs0_get), 65'd0);

    // Tie: both requesters three times; expect strict alternation starting with 0.
    do_reset(1'b0);
    repeat (3) begin
      stim0.push_back({32'h0, 1'b0, 32'h0});
      stim1.push_back({32'h4, 1'b0, 32'h0});
    end
    for (int c = 0; c < 60 && (rx0.size() + rx1.size()) < 6; c++) cycle(100, 100, 100, 100);
    check("tie_issued", 65'(mem_log.size()), 65'd6);
    for (int k = 0; k < mem_log.size() && k < 6; k++)
      check($sformatf("tie_order%0d", k), 65'(mem_log[k][64:33]), (k % 2) ? 65'h4 : 65'h0);
    check("tie_rx0_cnt", 65'(rx0.size()), 65'd3);
    check("tie_rx1_cnt", 65'(rx1.size()), 65'd3);
    for (int k = 0; k < rx0.size() && k < 3; k++)
      check($sformatf("tie_rx0_%0d", k), 65'(rx0[k]), 65'(2 * k + 1));
    for (int k = 0; k < rx1.size() && k < 3; k++)
      check($sformatf("tie_rx1_%0d", k), 65'(rx1[k]), 65'(2 * k + 2));

    // Tag FIFO full: memory takes without answering.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) stim0.push_back({32'h40 + 32'(4 * i), 1'b0, 32'h0});
    repeat (12) cycle(100, 100, 0, 100);
    check("tagfull_issued", 65'(mem_log.size()), 65'(TAG_DEPTH));
    check("tagfull_rdy_low", 65'(bus.RDY_mem_rq_get), 65'd0);
    check("tagfull_held_addr", 65'(bus.mem_rq_get[64:33]), 65'h50);
`ifdef MEM_ARB_PERF_EN
    check("tagfull_stall_seen", 65'(stall_count != 32'd0), 65'd1);
`endif
    cycle(0, 0, 100, 0);
    check("tagfull_rdy_back", 65'(bus.RDY_mem_rq_get), 65'd1);

    // Head-of-line: undrained rs0 blocks the next response.
    do_reset(1'b0);
    stim0.push_back({32'h10, 1'b0, 32'h0});
    stim0.push_back({32'h14, 1'b0, 32'h0});
    repeat (6) cycle(100, 100, 0, 0);
    check("hol_issued", 65'(mem_log.size()), 65'd2);
    cycle(0, 0, 100, 0);
    check("hol_rs0_rdy", 65'(bus.RDY_rs0_get), 65'd1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("hol_blocked%0d", c), 65'(bus.RDY_mem_rs_put), 65'd0);
      cycle(0, 0, 100, 0);
    end
    check("hol_blocked_deq_cycle", 65'(bus.RDY_mem_rs_put), 65'd0);
    cycle(0, 0, 0, 100);
    check("hol_unblocked", 65'(bus.RDY_mem_rs_put), 65'd1);
    cycle(0, 0, 100, 0);
    cycle(0, 0, 0, 0);
    check("hol_rs0_second", 65'(bus.rs0_get), 65'h2);
    check("hol_rs0_second_rdy", 65'(bus.RDY_rs0_get), 65'd1);
    cycle(0, 0, 0, 100);

    // Write from requester 1 gets one response.
    do_reset(1'b0);
    stim1.push_back({32'h20, 1'b1, 32'h12345678});
    repeat (8) cycle(100, 100, 100, 0);
    check("wr_issued", 65'(mem_log.size()), 65'd1);
    if (mem_log.size() > 0) check("wr_req", mem_log[0], {32'h20, 1'b1, 32'h12345678});
    check("wr_rs1_rdy", 65'(bus.RDY_rs1_get), 65'd1);
    check("wr_rs0_quiet", 65'(bus.RDY_rs0_get), 65'd0);
`ifdef MEM_ARB_PERF_EN
    check("wr_grant1", 65'(grant1_count), 65'd1);
    check("wr_grant0", 65'(grant0_count), 65'd0);
`endif
    cycle(0, 0, 0, 100);

    // Randomized traffic; requester id carried in address bit 31.
    do_reset(1'b0);
    seq_resp = 1'b0;
    for (int i = 0; i < 300; i++) begin
      stim0.push_back({1'b0, 31'($urandom), 1'($urandom), 32'($urandom)});
      stim1.push_back({1'b1, 31'($urandom), 1'($urandom), 32'($urandom)});
    end
    done = 1'b0;
    for (int c = 0; c < 6000 && !done; c++) begin
      cycle($urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(20, 100),
            $urandom_range(20, 100));
      done = stim0.size() == 0 && stim1.size() == 0 && sent0.size() == 0 &&
             sent1.size() == 0 && pend.size() == 0 && exp0.size() == 0 && exp1.size() == 0;
    end
    idle();
    check("rand_drained", 65'(done), 65'd1);
    check("rand_issued0", 65'(issued0), 65'd300);
    check("rand_issued1", 65'(issued1), 65'd300);
`ifdef MEM_ARB_PERF_EN
    check("rand_grant0", 65'(grant0_count), 65'(issued0));
    check("rand_grant1", 65'(grant1_count), 65'(issued1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
